// File: rtl/div_sequencer.sv
// div_sequencer: sequences signed/unsigned 32-bit divide and remainder
// requests through an external unsigned divider core.
// It drives the core with operand magnitudes, applies sign correction to
// the core's result, and answers divide-by-zero and signed-overflow
// requests directly without using the core.
// Optional feature macro: DIV_RESULT_CACHE_EN. When it is defined, the
// last core result is kept so a repeated operand pair (for example DIV
// then REM of the same operands) is answered without using the core.
module div_sequencer #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             core_valid,
   output logic [31:0]      core_a,
   output logic [31:0]      core_b,
   input  logic [31:0]      core_y,
   input  logic [31:0]      core_rem,
   input  logic             core_done
);

   localparam int DATA_W = 32;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;

   localparam logic [DATA_W-1:0] SIGNED_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ALL_ONES   = {DATA_W{1'b1}};

   typedef enum logic [1:0] {IDLE, RUN, FIX, RESP} state_t;

   state_t state;

   // Magnitude for the unsigned core. Negating 0x80000000 wraps back to
   // 0x80000000, which is the correct unsigned magnitude, so no saturation.
   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic sgn_op);
      logic signed [DATA_W-1:0] neg_v;
      neg_v = -v;
      if (sgn_op && v[DATA_W-1])
         return neg_v;
      return v;
   endfunction

   // Sign correction of the unsigned core result for the requested op.
   function automatic logic [DATA_W-1:0] sign_fix(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] q,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic sa,
                                                 input logic sb);
      logic signed [DATA_W-1:0] q_s;
      logic signed [DATA_W-1:0] r_s;
      logic [DATA_W-1:0]        neg_q;
      logic [DATA_W-1:0]        neg_r;
      q_s   = q;
      r_s   = r;
      neg_q = -q_s;
      neg_r = -r_s;
      case (op)
         OP_DIV:  return (sa ^ sb) ? neg_q : q;
         OP_REM:  return sa ? neg_r : r;
         OP_DIVU: return q;
         default: return r;
      endcase
   endfunction

   // Request decode: signedness, operand signs, fast-path detection.
   logic                     sgn_req;
   logic                     sa_req;
   logic                     sb_req;
   logic                     div_zero;
   logic                     sgn_ovf;
   logic                     fast_hit;
   logic [DATA_W-1:0]        fast_data;
   logic signed [DATA_W-1:0] req_a_s;
   logic signed [DATA_W-1:0] req_b_s;
   logic                     cache_hit;
   logic [DATA_W-1:0]        cache_data;

   assign req_a_s  = req_a;
   assign req_b_s  = req_b;
   assign sgn_req  = ~req_op[0];
   assign sa_req   = sgn_req & req_a[DATA_W-1];
   assign sb_req   = sgn_req & req_b[DATA_W-1];
   assign div_zero = (req_b == '0);
   assign sgn_ovf  = sgn_req && (req_a == SIGNED_MIN) && (req_b == ALL_ONES);
   assign fast_hit = div_zero || sgn_ovf;

   // Architectural results for divide-by-zero and signed overflow.
   always_comb begin
      fast_data = '0;
      if (div_zero)
         fast_data = req_op[1] ? req_a : ALL_ONES;
      else
         fast_data = req_op[1] ? '0 : SIGNED_MIN;
   end

   // Per-operation context and captured core outputs (datapath, no reset).
   logic [1:0]        op_r;
   logic [TAG_W-1:0]  tag_r;
   logic              sa_r;
   logic              sb_r;
   logic [DATA_W-1:0] q_r;
   logic [DATA_W-1:0] r_r;

   // Capture request context on transfer and core results on completion.
   always_ff @(posedge clk) begin
      if (req_ready && req_valid) begin
         op_r  <= req_op;
         tag_r <= req_tag;
         sa_r  <= sa_req;
         sb_r  <= sb_req;
      end
      if (state == RUN && core_done) begin
         q_r <= core_y;
         r_r <= core_rem;
      end
   end

`ifdef DIV_RESULT_CACHE_EN
   logic              cache_vld;
   logic              cache_sgn;
   logic [DATA_W-1:0] a_raw;
   logic [DATA_W-1:0] b_raw;
   logic [DATA_W-1:0] cache_a;
   logic [DATA_W-1:0] cache_b;
   logic [DATA_W-1:0] cache_q;
   logic [DATA_W-1:0] cache_r;

   // Keep the raw operands of the in-flight op so the cache key matches requests.
   always_ff @(posedge clk) begin
      if (req_ready && req_valid) begin
         a_raw <= req_a;
         b_raw <= req_b;
      end
   end

   // Cache validity: lost on reset and flush, set by each completed core op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cache_vld <= 1'b0;
      else if (flush)
         cache_vld <= 1'b0;
      else if (state == RUN && core_done)
         cache_vld <= 1'b1;
   end

   // Cache contents: uncorrected core outputs plus the key they belong to.
   always_ff @(posedge clk) begin
      if (state == RUN && core_done) begin
         cache_a   <= a_raw;
         cache_b   <= b_raw;
         cache_sgn <= ~op_r[0];
         cache_q   <= core_y;
         cache_r   <= core_rem;
      end
   end

   assign cache_hit  = cache_vld && (req_a == cache_a) && (req_b == cache_b) &&
                       (sgn_req == cache_sgn);
   assign cache_data = sign_fix(req_op, cache_q, cache_r, sa_req, sb_req);
`else
   assign cache_hit  = 1'b0;
   assign cache_data = '0;
`endif

   // Control FSM with registered handshake, core-enable and response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         core_valid <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         resp_data  <= '0;
         resp_tag   <= '0;
      end else if (flush) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         core_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (fast_hit || cache_hit) begin
                     resp_data  <= fast_hit ? fast_data : cache_data;
                     resp_tag   <= req_tag;
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     core_a     <= magnitude(req_a_s, sgn_req);
                     core_b     <= magnitude(req_b_s, sgn_req);
                     core_valid <= 1'b1;
                     state      <= RUN;
                  end
               end
            end
            RUN: begin
               if (core_done) begin
                  core_valid <= 1'b0;
                  state      <= FIX;
               end
            end
            FIX: begin
               resp_data  <= sign_fix(op_r, q_r, r_r, sa_r, sb_r);
               resp_tag   <= tag_r;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural multi-cycle
// unsigned divider core. The driver pushes hand-computed expectations;
// a separate monitor pops and compares on each response handshake.
module tb_div_sequencer;

   localparam int CORE_LAT = 4;
`ifdef DIV_RESULT_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif

   localparam logic [1:0] DIV  = 2'b00;
   localparam logic [1:0] DIVU = 2'b01;
   localparam logic [1:0] REM  = 2'b10;
   localparam logic [1:0] REMU = 2'b11;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_tag;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_tag;
   logic        core_valid;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic [31:0] core_y;
   logic [31:0] core_rem;
   logic        core_done;
   logic        stray_done;
   int          core_cnt;
   int          edge_cnt;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      int          t_edge;
      int          lat;
      bit          core;
   } exp_t;

   exp_t sb_q[$];

   int n_pass;
   int n_total;

   // Reference cache model: last core-path key
   bit          m_cvld;
   logic [31:0] m_ca;
   logic [31:0] m_cb;
   bit          m_cs;

   div_sequencer #(.TAG_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag),
      .core_valid (core_valid),
      .core_a     (core_a),
      .core_b     (core_b),
      .core_y     (core_y),
      .core_rem   (core_rem),
      .core_done  (core_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Behavioural core: done on its CORE_LAT-th enabled cycle
   always @(posedge clk) begin
      if (!core_valid) core_cnt <= 0;
      else             core_cnt <= core_cnt + 1;
   end
   assign core_done = (core_valid && core_cnt == CORE_LAT - 1) || stray_done;
   assign core_y    = (core_b == 0) ? 32'd0 : core_a / core_b;
   assign core_rem  = (core_b == 0) ? 32'd0 : core_a % core_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Issue one request (called at a negedge); returns at the negedge after transfer
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_data);
      exp_t e;
      bit   sgn;
      bit   fast;
      int   n;
      sgn  = ~op[0];
      fast = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("req_accepted", req_ready, 1'b1);
      e.data   = exp_data;
      e.tag    = tag;
      e.t_edge = edge_cnt + 1;
      if (fast) begin
         e.lat  = 1;
         e.core = 0;
      end else if (CACHE_ON && m_cvld && m_ca == a && m_cb == b && m_cs == sgn) begin
         e.lat  = 1;
         e.core = 0;
      end else begin
         e.lat  = CORE_LAT + 2;
         e.core = 1;
         m_cvld = 1;
         m_ca   = a;
         m_cb   = b;
         m_cs   = sgn;
      end
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb_q.size(), 0);
   endtask

   // Monitor: compares each presented response against the scoreboard head
   bit          resp_seen;
   bit          core_seen;
   logic [31:0] held_data;
   logic [4:0]  held_tag;

   always @(negedge clk) begin
      #1;
      if (core_valid) core_seen = 1;
      if (!reset || flush) begin
         resp_seen = 0;
         core_seen = 0;
      end else if (resp_valid) begin
         if (!resp_seen) begin
            resp_seen = 1;
            held_data = resp_data;
            held_tag  = resp_tag;
            if (sb_q.size() == 0) begin
               check("unexpected_resp", resp_valid, 1'b0);
            end else begin
               check("resp_data", resp_data, sb_q[0].data);
               check("resp_tag", resp_tag, sb_q[0].tag);
               check("latency", edge_cnt - sb_q[0].t_edge + 1, sb_q[0].lat);
               check("core_used", core_seen, sb_q[0].core);
            end
         end else begin
            check("resp_data_stable", resp_data, held_data);
            check("resp_tag_stable", resp_tag, held_tag);
         end
         if (resp_ready) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            resp_seen = 0;
            core_seen = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      n_pass = 0; n_total = 0; edge_cnt = 0; core_cnt = 0;
      m_cvld = 0; m_ca = 0; m_cb = 0; m_cs = 0;
      resp_seen = 0; core_seen = 0; held_data = 0; held_tag = 0;
      reset = 1'b0; flush = 1'b0; stray_done = 1'b0;
      req_valid = 1'b0; req_op = 0; req_a = 0; req_b = 0; req_tag = 0;
      resp_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_core_valid", core_valid, 1'b0);
      check("rst_core_a", core_a, 0);
      check("rst_core_b", core_b, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_tag", resp_tag, 0);
      reset = 1'b1;
      @(negedge clk);

      // Signed and unsigned core-path operations
      send(DIV,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD);
      send(REM,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF);
      send(DIVU, 32'd100, 32'd7, 5'd3, 32'd14);
      send(REMU, 32'd100, 32'd7, 5'd4, 32'd2);
      send(DIV,  32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD);
      send(REM,  32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1);
      send(DIV,  32'h8000_0000, 32'd2, 5'd7, 32'hC000_0000);
      send(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0);
      send(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);

      // Fast-path cases
      send(DIV,  32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
      send(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0);
      send(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
      send(DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
      send(REMU, 32'd5, 32'd0, 5'd14, 32'd5);
      wait_drain();

      // Back-pressure: response held, no new request accepted
      resp_ready = 1'b0;
      send(DIVU, 32'd100, 32'd3, 5'd15, 32'd33);
      n = 0;
      while (!resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_resp_valid", resp_valid, 1'b1);
      req_valid = 1'b1; req_op = DIVU; req_a = 32'd45; req_b = 32'd5; req_tag = 5'd16;
      repeat (5) begin
         @(negedge clk);
         check("hold_req_ready", req_ready, 1'b0);
         check("hold_resp_valid_high", resp_valid, 1'b1);
      end
      resp_ready = 1'b1;
      send(DIVU, 32'd45, 32'd5, 5'd16, 32'd9);
      wait_drain();

      // Flush during RUN, then a fresh op
      send(DIVU, 32'd200, 32'd7, 5'd17, 32'd28);
      @(negedge clk);
      flush = 1'b1;
      sb_q.delete();
      m_cvld = 0;
      @(negedge clk);
      flush = 1'b0;
      check("flush_core_valid", core_valid, 1'b0);
      check("flush_req_ready", req_ready, 1'b1);
      send(DIVU, 32'd9, 32'd3, 5'd18, 32'd3);
      wait_drain();

      // Stray core_done while idle is ignored
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      @(negedge clk);
      check("stray_req_ready", req_ready, 1'b1);
      check("stray_resp_valid", resp_valid, 1'b0);

      // Reset in the middle of an operation
      send(DIVU, 32'd50, 32'd7, 5'd19, 32'd7);
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      m_cvld = 0;
      @(negedge clk);
      check("midrst_req_ready", req_ready, 1'b1);
      check("midrst_core_valid", core_valid, 1'b0);
      check("midrst_core_a", core_a, 0);
      check("midrst_resp_valid", resp_valid, 1'b0);
      reset = 1'b1;
      repeat (8) @(negedge clk);

      // Result reuse for identical operands; new divisor needs the core
      send(DIV, 32'd1000, 32'd7, 5'd20, 32'd142);
      send(REM, 32'd1000, 32'd7, 5'd21, 32'd6);
      send(DIV, 32'd1000, 32'd8, 5'd22, 32'd125);
      wait_drain();
      flush = 1'b1;
      m_cvld = 0;
      @(negedge clk);
      flush = 1'b0;
      send(REM, 32'd1000, 32'd8, 5'd23, 32'd0);
      wait_drain();

      repeat (4) @(negedge clk);
      check("final_queue_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
